// File: rtl/wb_sp_ram32.sv
// wb_sp_ram32: single-port 32-bit synchronous RAM with a pipelined Wishbone B4 slave port.
// It is the program/data memory behind the Ibex SoC shared-bus interconnect.
//
// Parameters:
//   size - memory size in bytes (power of two, >= 8); depth = size/4 words
//   AW   - derived byte-address width, $clog2(size)
// Ports:
//   clk, rst            - clock (rising edge) and synchronous active-high reset
//   wb_cyc, wb_stb      - bus cycle / request strobe
//   wb_we               - 1 = write, 0 = read
//   wb_adr              - byte address; bits [AW-1:2] select the word
//   wb_sel              - byte enables for writes
//   wb_dat_i / wb_dat_o - write data in / read data out
//   wb_ack              - request completed, one cycle after accept
//   wb_stall            - high only while in reset
//   wb_err              - out-of-range termination (only with SPRAM_RANGE_CHECK_EN)
//
// Build option: define SPRAM_RANGE_CHECK_EN to flag requests with
// wb_adr[31:AW] != 0 with wb_err instead of aliasing them into the array.
// Without it wb_err is tied low and upper address bits are ignored.
//
// `mem` is never reset so a bench can preload it hierarchically.

module wb_sp_ram32 #(
  parameter  int size = 'h10000,
  localparam int AW   = $clog2(size)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_cyc,
  input  logic        wb_stb,
  input  logic        wb_we,
  input  logic [31:0] wb_adr,
  input  logic [3:0]  wb_sel,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack,
  output logic        wb_stall,
  output logic        wb_err
);

  logic [31:0] mem [size/4];

  logic [AW-3:0] idx_p0;
  logic          accept_p0;
  logic          oor_p0;
  logic          ack_p1;
  logic [31:0]   dat_p1;

  // Stage p0: request decode in the accept cycle
  assign wb_stall  = rst;
  assign accept_p0 = wb_cyc & wb_stb & ~wb_stall;
  assign idx_p0    = wb_adr[AW-1:2];

`ifdef SPRAM_RANGE_CHECK_EN
  logic err_p1;
  logic unused_adr;

  assign oor_p0     = |wb_adr[31:AW];
  assign unused_adr = ^wb_adr[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      err_p1 <= 1'b0;
    end else begin
      err_p1 <= accept_p0 & oor_p0;
    end
  end

  // Error response is masked by wb_cyc exactly like ack.
  assign wb_err = err_p1 & wb_cyc;
`else
  logic unused_adr;

  assign oor_p0     = 1'b0;
  assign unused_adr = ^{wb_adr[31:AW], wb_adr[1:0]};
  assign wb_err     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (accept_p0 && wb_we && !oor_p0) begin
      for (int i = 0; i < 4; i++) begin
        if (wb_sel[i]) mem[idx_p0][8*i +: 8] <= wb_dat_i[8*i +: 8];
      end
    end
  end

  // Stage p1: registered response, visible the cycle after accept
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_p1 <= 1'b0;
      dat_p1 <= 32'h0;
    end else begin
      ack_p1 <= accept_p0 & ~oor_p0;
      if (accept_p0 && !wb_we && !oor_p0) dat_p1 <= mem[idx_p0];
    end
  end

  // A master that drops wb_cyc abandons the pending response; since accept
  // needs wb_cyc, ack_p1 also clears on the following edge.
  assign wb_ack   = ack_p1 & wb_cyc;
  assign wb_dat_o = dat_p1;

endmodule

// File: tb/tb_wb_sp_ram32.sv
module tb_wb_sp_ram32;

  localparam int SIZE = 'h10000;
  localparam int AWB  = $clog2(SIZE);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [31:0] adr = '0, dati = '0;
  logic [3:0]  sel = '0;
  logic [31:0] dato;
  logic        ack, stall, err;

  int tests = 0;
  int fails = 0;

  wb_sp_ram32 #(.size(SIZE)) dut (
    .clk(clk), .rst(rst), .wb_cyc(cyc), .wb_stb(stb), .wb_we(we),
    .wb_adr(adr), .wb_sel(sel), .wb_dat_i(dati), .wb_dat_o(dato),
    .wb_ack(ack), .wb_stall(stall), .wb_err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: word-addressed memory plus "what response is owed next cycle".
  logic [31:0] model_mem [int];
  logic        owe_ack = 1'b0, owe_err = 1'b0;
  logic [31:0] last_rd = 32'h0;
  bit          started = 1'b0;

  function automatic bit out_of_range(input logic [31:0] a);
`ifdef SPRAM_RANGE_CHECK_EN
    return (a >> AWB) != 0;
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk) begin
    int widx;
    logic [31:0] w;
    started = 1'b1;
    widx = int'((adr % SIZE) / 4);
    if (rst) begin
      owe_ack = 1'b0;
      owe_err = 1'b0;
      last_rd = 32'h0;
    end else begin
      owe_ack = cyc && stb && !out_of_range(adr);
      owe_err = cyc && stb && out_of_range(adr);
      if (owe_ack && !we)
        last_rd = model_mem.exists(widx) ? model_mem[widx] : 32'h0;
      if (owe_ack && we) begin
        w = model_mem.exists(widx) ? model_mem[widx] : 32'h0;
        for (int b = 0; b < 4; b++)
          if (sel[b]) w[8*b +: 8] = dati[8*b +: 8];
        model_mem[widx] = w;
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      chk("cmp_stall", {31'b0, stall}, {31'b0, rst});
      chk("cmp_ack",   {31'b0, ack},   {31'b0, owe_ack & cyc});
      chk("cmp_err",   {31'b0, err},   {31'b0, owe_err & cyc});
      chk("cmp_dat",   dato,           last_rd);
    end
  end

  // Present one request for one accept edge; returns #1 after that edge.
  task automatic req(input logic w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dati = d;
    @(posedge clk); #1;
  endtask

  task automatic gap();
    stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string name);
    req(1'b0, a, 4'h0, 32'h0);
    chk({name, "_ack"}, {31'b0, ack}, 32'd1);
    chk({name, "_dat"}, dato, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack",   {31'b0, ack},   32'd0);
    chk("rst_err",   {31'b0, err},   32'd0);
    chk("rst_stall", {31'b0, stall}, 32'd1);
    chk("rst_dat",   dato,           32'h0);
    rst = 1'b0;
    #1;
    chk("stall_low", {31'b0, stall}, 32'd0);

    // Preload through the bus.
    req(1'b1, 32'h0,  4'hF, 32'hDEADBEEF);
    chk("wr_ack", {31'b0, ack}, 32'd1);
    req(1'b1, 32'h4,  4'hF, 32'h01010101);
    req(1'b1, 32'h8,  4'hF, 32'h02020202);
    req(1'b1, 32'hC,  4'hF, 32'h0C0C0C0C);
    req(1'b1, 32'h10, 4'hF, 32'h00000000);
    chk("wr_no_dat", dato, 32'h0);
    gap();

    rd(32'h0, 32'hDEADBEEF, "rd0");
    gap();

    // Partial write then immediate read-after-write.
    req(1'b1, 32'h10, 4'b0101, 32'h11223344);
    rd(32'h10, 32'h00220044, "raw10");
    gap();

    // Back-to-back pipelined reads.
    rd(32'h0, 32'hDEADBEEF, "pipe0");
    rd(32'h4, 32'h01010101, "pipe4");
    rd(32'h8, 32'h02020202, "pipe8");
    // A write does not disturb wb_dat_o.
    req(1'b1, 32'hC, 4'hF, 32'hC0C0C0C0);
    chk("wr_hold_dat", dato, 32'h02020202);
    // sel=0 write acks but changes nothing.
    req(1'b1, 32'h0, 4'h0, 32'hFFFFFFFF);
    chk("sel0_ack", {31'b0, ack}, 32'd1);
    rd(32'h0, 32'hDEADBEEF, "sel0_rd");
    rd(32'h3, 32'hDEADBEEF, "lowbits");
    rd(32'hC, 32'hC0C0C0C0, "rdC");
    gap();

    // Drop cyc with an ack pending.
    req(1'b0, 32'h4, 4'h0, 32'h0);
    cyc = 1'b0; stb = 1'b0;
    #1;
    chk("drop_mask", {31'b0, ack}, 32'd0);
    @(posedge clk); #1;
    cyc = 1'b1;
    #1;
    chk("drop_noleak", {31'b0, ack}, 32'd0);

    // stb without cyc is ignored.
    cyc = 1'b0; stb = 1'b1; we = 1'b1; adr = 32'h0; sel = 4'hF; dati = 32'hFFFFFFFF;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b0; we = 1'b0;
    #1;
    chk("stb_only_ack", {31'b0, ack}, 32'd0);
    rd(32'h0, 32'hDEADBEEF, "stb_only_rd");
    gap();

    // Reset asserted during a write accept.
    rst = 1'b1;
    req(1'b1, 32'h4, 4'hF, 32'hCAFEF00D);
    chk("rstwr_ack", {31'b0, ack}, 32'd0);
    chk("rstwr_dat", dato, 32'h0);
    chk("rstwr_stall", {31'b0, stall}, 32'd1);
    rst = 1'b0;
    gap();
    rd(32'h4, 32'h01010101, "rstwr_rd");
    gap();

    // Address beyond size.
`ifdef SPRAM_RANGE_CHECK_EN
    req(1'b0, SIZE, 4'h0, 32'h0);
    chk("oor_err", {31'b0, err}, 32'd1);
    chk("oor_ack", {31'b0, ack}, 32'd0);
    chk("oor_dat", dato, 32'h01010101);
    req(1'b1, SIZE + 4, 4'hF, 32'h00000055);
    chk("oorw_err", {31'b0, err}, 32'd1);
    rd(32'h4, 32'h01010101, "oorw_rd");
`else
    rd(SIZE, 32'hDEADBEEF, "alias_rd");
    req(1'b1, SIZE + 4, 4'hF, 32'h00000055);
    chk("alias_err", {31'b0, err}, 32'd0);
    rd(32'h4, 32'h00000055, "alias_wr");
`endif
    gap();
    cyc = 1'b0;
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
